// File: rtl/moon_pkg.sv
// Shared state encodings, screen geometry and per-axis helpers for the moon
// sprite motion controller.
package moon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHASE   = 2'd1,
    HIT     = 2'd2,
    RESPAWN = 2'd3
  } moon_state_t;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned MOON_SIZE = 32;

  localparam logic [9:0] START_X = 10'd304;
  localparam logic [9:0] START_Y = 10'd40;
  localparam logic [9:0] MAX_X   = 10'(SCREEN_W - MOON_SIZE);
  localparam logic [9:0] MAX_Y   = 10'(SCREEN_H - MOON_SIZE);

  // One axis step toward target: snap when within step, else move by step,
  // then clamp into 0..max so the position never wraps.
  function automatic logic [9:0] step_axis(input logic [9:0]  pos,
                                           input logic [9:0]  target,
                                           input logic [9:0]  max,
                                           input logic [11:0] step);
    logic signed [11:0] d;
    logic signed [11:0] mv;
    logic signed [11:0] nxt;
    d = $signed({2'b00, target}) - $signed({2'b00, pos});
    if (d > $signed(step))       mv = $signed(step);
    else if (d < -$signed(step)) mv = -$signed(step);
    else                         mv = d;
    nxt = $signed({2'b00, pos}) + mv;
    if (nxt[11])                            return '0;
    else if (nxt > $signed({2'b00, max}))   return max;
    else                                    return nxt[9:0];
  endfunction

  function automatic logic [10:0] abs_diff(input logic [9:0] a,
                                           input logic [9:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

endpackage

// File: rtl/moon_motion_ctrl_period_timer.sv
// Speed-scaled move tick: period = BASE_PERIOD - speed_offset, floored at
// MIN_PERIOD; counter runs only while run is high.
module moon_period_timer #(
  parameter int unsigned BASE_PERIOD = 2000000,
  parameter int unsigned MIN_PERIOD  = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [25:0] speed_offset,
  output logic        move_tick
);

  logic [26:0] diff;
  logic [26:0] eff;
  logic [26:0] cnt;

  always_comb begin
    diff = 27'(BASE_PERIOD) - {1'b0, speed_offset};
    if (diff[26] || (diff < 27'(MIN_PERIOD))) eff = 27'(MIN_PERIOD);
    else                                       eff = diff;
  end

  // >= rather than == so a shortened period mid-count still fires at once.
  assign move_tick = run && (cnt >= (eff - 27'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         cnt <= '0;
    else if (!run)      cnt <= '0;
    else if (move_tick) cnt <= '0;
    else                cnt <= cnt + 27'd1;
  end

endmodule

// File: rtl/moon_motion_ctrl.sv
// Moon sprite chase controller: steps a shadow position toward the player,
// detects hits, runs chase/hit/respawn and publishes on frame boundaries.
module moon_motion_ctrl
  import moon_pkg::*;
#(
  parameter int unsigned BASE_PERIOD    = 2000000,
  parameter int unsigned MIN_PERIOD     = 200000,
  parameter int unsigned STEP           = 2,
  parameter int unsigned HIT_RADIUS     = 16,
  parameter int unsigned HIT_FRAMES     = 30,
  parameter int unsigned RESPAWN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_tick,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [25:0] speed_offset,
  output logic [9:0]  moon_x,
  output logic [9:0]  moon_y,
  output logic        moon_visible,
  output logic        collide,
  output logic [1:0]  state
);

  localparam logic [11:0] STEP_W = 12'(STEP);

  moon_state_t cur, state_next;
  logic [9:0]  shadow_x, shadow_y, shadow_x_next, shadow_y_next;
  logic [7:0]  frame_cnt, frame_next;
  logic        collide_next;
  logic        move_tick;
  logic        hit;

  moon_period_timer #(
    .BASE_PERIOD (BASE_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .run          (cur == CHASE),
    .speed_offset (speed_offset),
    .move_tick    (move_tick)
  );

  always_comb begin
    state_next    = cur;
    shadow_x_next = shadow_x;
    shadow_y_next = shadow_y;
    frame_next    = frame_cnt;
    collide_next  = 1'b0;
    hit = (cur == CHASE) &&
          (abs_diff(player_x, shadow_x) < 11'(HIT_RADIUS)) &&
          (abs_diff(player_y, shadow_y) < 11'(HIT_RADIUS));
    if (!enable) begin
      state_next = IDLE;
      frame_next = '0;
    end else begin
      case (cur)
        IDLE: state_next = CHASE;
        CHASE: begin
          // A hit wins over a same-cycle move; the step is discarded.
          if (hit) begin
            state_next   = HIT;
            frame_next   = '0;
            collide_next = 1'b1;
          end else if (move_tick) begin
            shadow_x_next = step_axis(shadow_x, player_x, MAX_X, STEP_W);
            shadow_y_next = step_axis(shadow_y, player_y, MAX_Y, STEP_W);
          end
        end
        HIT: begin
          if (frame_tick) begin
            if (frame_cnt + 8'd1 == 8'(HIT_FRAMES)) begin
              state_next    = RESPAWN;
              frame_next    = '0;
              shadow_x_next = START_X;
              shadow_y_next = START_Y;
            end else begin
              frame_next = frame_cnt + 8'd1;
            end
          end
        end
        RESPAWN: begin
          if (frame_tick) begin
            if (frame_cnt + 8'd1 == 8'(RESPAWN_FRAMES)) begin
              state_next = CHASE;
              frame_next = '0;
            end else begin
              frame_next = frame_cnt + 8'd1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= IDLE;
      shadow_x  <= START_X;
      shadow_y  <= START_Y;
      frame_cnt <= '0;
      collide   <= 1'b0;
      moon_x    <= START_X;
      moon_y    <= START_Y;
    end else begin
      cur       <= state_next;
      shadow_x  <= shadow_x_next;
      shadow_y  <= shadow_y_next;
      frame_cnt <= frame_next;
      collide   <= collide_next;
      // Publishes the pre-step shadow when a move lands on the same edge.
      if (frame_tick) begin
        moon_x <= shadow_x;
        moon_y <= shadow_y;
      end
    end
  end

  assign state        = cur;
  assign moon_visible = (cur == CHASE) || (cur == HIT);

endmodule

// File: tb/tb_moon_motion_ctrl.sv
// Directed bench for moon_motion_ctrl with short periods and frame counts.
module tb_moon_motion_ctrl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        frame_tick;
  logic [9:0]  player_x;
  logic [9:0]  player_y;
  logic [25:0] speed_offset;
  logic [9:0]  moon_x;
  logic [9:0]  moon_y;
  logic        moon_visible;
  logic        collide;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  moon_motion_ctrl #(
    .BASE_PERIOD    (8),
    .MIN_PERIOD     (4),
    .STEP           (2),
    .HIT_RADIUS     (16),
    .HIT_FRAMES     (2),
    .RESPAWN_FRAMES (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .frame_tick   (frame_tick),
    .player_x     (player_x),
    .player_y     (player_y),
    .speed_offset (speed_offset),
    .moon_x       (moon_x),
    .moon_y       (moon_y),
    .moon_visible (moon_visible),
    .collide      (collide),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    cycles(1);
    frame_tick = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; frame_tick = 1'b0;
    player_x = 10'd300; player_y = 10'd400; speed_offset = '0;
    cycles(3);
    check("rst_state",   32'(state), 32'd0);
    check("rst_x",       32'(moon_x), 32'd304);
    check("rst_y",       32'(moon_y), 32'd40);
    check("rst_visible", 32'(moon_visible), 32'd0);
    check("rst_collide", 32'(collide), 32'd0);

    // Chase at period 8: steps land on E9, E17, E25, E33, E41, ...
    reset = 1'b1; enable = 1'b1;
    cycles(1);
    check("chase_state",   32'(state), 32'd1);
    check("chase_visible", 32'(moon_visible), 32'd1);
    cycles(19);
    frame();
    check("pub1_x", 32'(moon_x), 32'd300);
    check("pub1_y", 32'(moon_y), 32'd44);

    // Frame coincides with the E41 step: pre-step value, then stepped one.
    cycles(19);
    frame();
    check("coincide_pre_y",  32'(moon_y), 32'd48);
    frame();
    check("coincide_post_y", 32'(moon_y), 32'd50);

    // Period floored at 4 both for eff=2 and for an underflowing offset.
    speed_offset = 26'd6;
    cycles(15);
    frame();
    check("fast_y", 32'(moon_y), 32'd58);
    speed_offset = 26'h3FFFFFF;
    cycles(15);
    frame();
    check("uflow_y", 32'(moon_y), 32'd66);
    check("hold_x",  32'(moon_x), 32'd300);

    // Drive toward the x=0 edge and past the bottom edge: clamps, no wrap.
    player_x = 10'd0; player_y = 10'd1000;
    cycles(1000);
    frame();
    check("clamp_x", 32'(moon_x), 32'd0);
    check("clamp_y", 32'(moon_y), 32'd448);

    // Collision from shadow (0,448).
    player_x = 10'd10; player_y = 10'd440;
    cycles(1);
    check("hit_collide", 32'(collide), 32'd1);
    check("hit_state",   32'(state), 32'd2);
    check("hit_visible", 32'(moon_visible), 32'd1);
    cycles(1);
    check("hit_pulse_end", 32'(collide), 32'd0);
    frame();
    check("hit_f1_state", 32'(state), 32'd2);
    frame();
    check("resp_state",   32'(state), 32'd3);
    check("resp_visible", 32'(moon_visible), 32'd0);
    frame();
    frame();
    check("resp_f2_state", 32'(state), 32'd3);
    frame();
    check("rechase_state", 32'(state), 32'd1);
    frame();
    check("rechase_x", 32'(moon_x), 32'd304);
    check("rechase_y", 32'(moon_y), 32'd40);

    // Enable toggles in chase hold the shadow and resume from it.
    enable = 1'b0;
    cycles(1);
    check("dis_state",   32'(state), 32'd0);
    check("dis_visible", 32'(moon_visible), 32'd0);
    cycles(3);
    enable = 1'b1;
    cycles(1);
    check("en1_state", 32'(state), 32'd1);
    cycles(5);
    frame();
    check("en1_x", 32'(moon_x), 32'd302);
    check("en1_y", 32'(moon_y), 32'd42);
    enable = 1'b0;
    cycles(5);
    frame();
    check("idle_state", 32'(state), 32'd0);
    check("idle_x", 32'(moon_x), 32'd302);
    check("idle_y", 32'(moon_y), 32'd42);
    enable = 1'b1;
    cycles(1);
    check("en2_state", 32'(state), 32'd1);
    cycles(5);
    frame();
    check("en2_x", 32'(moon_x), 32'd300);
    check("en2_y", 32'(moon_y), 32'd44);

    // Hit, then asynchronous reset between clock edges.
    player_x = 10'd300; player_y = 10'd50;
    cycles(1);
    check("ahit_state",   32'(state), 32'd2);
    check("ahit_collide", 32'(collide), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("arst_state",   32'(state), 32'd0);
    check("arst_x",       32'(moon_x), 32'd304);
    check("arst_y",       32'(moon_y), 32'd40);
    check("arst_visible", 32'(moon_visible), 32'd0);
    check("arst_collide", 32'(collide), 32'd0);
    cycles(2);
    reset = 1'b1;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
